// File: rtl/up_cmd_master_if.sv
// up_cmd_master_if: command/response handshake and up_* bus bundle.
// master = command engine, slave = sequencer plus bus slave.
interface up_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_op;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [15:0]       rsp_tries;
  logic              busy;
  logic              up_cs;
  logic              up_wr;
  logic              up_rd;
  logic [ADDR_W-1:0] up_addr;
  logic [DATA_W-1:0] up_data_wr;
  logic [DATA_W-1:0] up_data_rd;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  rsp_ready, up_data_rd,
    output cmd_ready, rsp_valid, rsp_op, rsp_data,
    output rsp_err, rsp_tries, busy,
    output up_cs, up_wr, up_rd, up_addr, up_data_wr
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    output rsp_ready, up_data_rd,
    input  cmd_ready, rsp_valid, rsp_op, rsp_data,
    input  rsp_err, rsp_tries, busy,
    input  up_cs, up_wr, up_rd, up_addr, up_data_wr
  );
endinterface

// File: rtl/up_cmd_master.sv
// up_cmd_master: rd/wr/poll/wait command engine for the up_* bus.
// One command in flight; registered bus strobes and responses.
module up_cmd_master #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 2,
  parameter int POLL_MAX = 1024,
  parameter int WAIT_W   = 24
) (
  input logic             up_clk,
  input logic             up_rst_n,
  up_cmd_master_if.master bus
);
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [1:0] OP_WAIT = 2'b11;

  typedef enum logic [2:0] {
    IDLE, STROBE, RDWAIT, SAMPLE, GAP, WAITCNT, RESP
  } state_t;

  state_t            state_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [15:0]       tries_q;
  logic [LAT_W-1:0]  lat_q;
  logic [WAIT_W-1:0] wcnt_q;
  logic              cs_q;
  logic              wr_q;
  logic              rd_q;
  logic [ADDR_W-1:0] up_addr_q;
  logic [DATA_W-1:0] up_wdata_q;
  logic              rsp_valid_q;
  logic [1:0]        rsp_op_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic [15:0]       rsp_tries_q;

  logic [15:0]       tries_d;
  logic              hit_d;
  logic              tmo_d;
  logic [WAIT_W-1:0] wait_n;

  // Poll bookkeeping for the read being sampled this cycle
  always_comb begin
    tries_d = (tries_q == 16'hFFFF) ? tries_q : tries_q + 16'd1;
    hit_d   = (bus.up_data_rd & data_q) == data_q;
    tmo_d   = (POLL_MAX != 0) &&
              ({16'd0, tries_d} == 32'(POLL_MAX));
    wait_n  = bus.cmd_data[WAIT_W-1:0];
  end

  // Command FSM with registered bus strobes and response
  always_ff @(posedge up_clk or negedge up_rst_n) begin
    if (!up_rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tries_q     <= '0;
      lat_q       <= '0;
      wcnt_q      <= '0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      up_addr_q   <= '0;
      up_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tries_q <= '0;
    end else begin
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      up_addr_q  <= '0;
      up_wdata_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q    <= bus.cmd_op;
            addr_q  <= bus.cmd_addr;
            data_q  <= bus.cmd_data;
            tries_q <= '0;
            if (bus.cmd_op == OP_WAIT) begin
              wcnt_q <= wait_n;
              if (wait_n == '0) begin
                state_q     <= RESP;
                rsp_valid_q <= 1'b1;
                rsp_op_q    <= OP_WAIT;
                rsp_data_q  <= '0;
                rsp_err_q   <= 1'b0;
                rsp_tries_q <= '0;
              end else begin
                state_q <= WAITCNT;
              end
            end else begin
              state_q   <= STROBE;
              cs_q      <= 1'b1;
              wr_q      <= (bus.cmd_op == OP_WR);
              rd_q      <= (bus.cmd_op != OP_WR);
              up_addr_q <= bus.cmd_addr;
              up_wdata_q <= (bus.cmd_op == OP_WR) ?
                            bus.cmd_data : '0;
            end
          end
        end
        STROBE: begin
          if (op_q == OP_WR) begin
            state_q <= GAP;
          end else if (RD_LAT == 1) begin
            state_q <= SAMPLE;
          end else begin
            state_q <= RDWAIT;
            lat_q   <= LAT_W'(RD_LAT - 1);
          end
        end
        RDWAIT: begin
          if (lat_q == LAT_W'(1)) state_q <= SAMPLE;
          else lat_q <= lat_q - LAT_W'(1);
        end
        SAMPLE: begin
          tries_q <= tries_d;
          if (op_q == OP_RD || hit_d || tmo_d) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_op_q    <= op_q;
            rsp_data_q  <= bus.up_data_rd;
            rsp_err_q   <= (op_q == OP_POLL) && !hit_d;
            rsp_tries_q <= tries_d;
          end else begin
            state_q <= GAP;
          end
        end
        GAP: begin
          if (op_q == OP_WR) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_op_q    <= OP_WR;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tries_q <= '0;
          end else begin
            state_q   <= STROBE;
            cs_q      <= 1'b1;
            rd_q      <= 1'b1;
            up_addr_q <= addr_q;
          end
        end
        WAITCNT: begin
          if (wcnt_q == WAIT_W'(1)) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_op_q    <= OP_WAIT;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tries_q <= '0;
          end else begin
            wcnt_q <= wcnt_q - WAIT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_op_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tries_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = up_rst_n & (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.up_cs      = cs_q;
  assign bus.up_wr      = wr_q;
  assign bus.up_rd      = rd_q;
  assign bus.up_addr    = up_addr_q;
  assign bus.up_data_wr = up_wdata_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_op     = rsp_op_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_tries  = rsp_tries_q;
endmodule

// File: tb/tb_up_cmd_master.sv
// tb_up_cmd_master: directed and randomized bench for up_cmd_master.
// Bus slave and response timing come from a behavioural model.
module tb_up_cmd_master;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int RD_LAT   = 2;
  localparam int POLL_MAX = 4;
  localparam int WAIT_W   = 24;
  localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  up_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if ();

  up_cmd_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
    .POLL_MAX(POLL_MAX), .WAIT_W(WAIT_W)
  ) dut (
    .up_clk(clk),
    .up_rst_n(rst_n),
    .bus(u_if.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] vals [16];
  int vidx;

  int          obs_lat, obs_nstr, obs_dirty, obs_idle;
  int          obs_nwr, obs_badrd;
  int          obs_k [16];
  logic [31:0] obs_addr, obs_wdata;
  logic        obs_rdy;
  logic [1:0]  r_op;
  logic [31:0] r_data;
  logic        r_err;
  logic [15:0] r_tries;

  logic outs_nz;
  assign outs_nz = |{u_if.cmd_ready, u_if.busy, u_if.rsp_valid,
                     u_if.rsp_op, u_if.rsp_data, u_if.rsp_err,
                     u_if.rsp_tries, u_if.up_cs, u_if.up_wr,
                     u_if.up_rd, u_if.up_addr, u_if.up_data_wr};

  // Drive one command and observe bus/response until rsp_valid.
  // The bus slave returns vals[] exactly RD_LAT cycles after a strobe.
  task automatic issue(input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] data);
    int k;
    int last;
    @(negedge clk);
    obs_rdy = u_if.cmd_ready;
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = op;
    u_if.cmd_addr  = addr;
    u_if.cmd_data  = data;
    @(posedge clk);
    #1;
    u_if.cmd_valid = 1'b0;
    u_if.cmd_op    = 2'($urandom_range(0, 3));
    u_if.cmd_addr  = $urandom;
    u_if.cmd_data  = $urandom;
    obs_lat = -1; obs_nstr = 0; obs_dirty = 0; obs_idle = 0;
    obs_nwr = 0; obs_badrd = 0; obs_addr = '0; obs_wdata = '0;
    last = -100; vidx = 0; k = 0;
    while (obs_lat < 0 && k < 200) begin
      @(negedge clk);
      k++;
      if (u_if.up_cs && (u_if.up_rd ^ u_if.up_wr)) begin
        if (obs_nstr < 16) obs_k[obs_nstr] = k;
        obs_nstr++;
        last = k;
        obs_addr = u_if.up_addr;
        if (u_if.up_wr) begin
          obs_nwr++;
          obs_wdata = u_if.up_data_wr;
        end else if (u_if.up_data_wr != '0) begin
          obs_badrd++;
        end
      end else if (u_if.up_cs || u_if.up_rd || u_if.up_wr ||
                   u_if.up_addr != '0 || u_if.up_data_wr != '0) begin
        obs_dirty++;
      end
      if (!u_if.busy) obs_idle++;
      if (u_if.rsp_valid) begin
        obs_lat = k;
        r_op = u_if.rsp_op;
        r_data = u_if.rsp_data;
        r_err = u_if.rsp_err;
        r_tries = u_if.rsp_tries;
      end
      if (k == last + RD_LAT && vidx < 16) begin
        u_if.up_data_rd = vals[vidx];
        vidx++;
      end else begin
        u_if.up_data_rd = JUNK;
      end
    end
    u_if.up_data_rd = JUNK;
  endtask

  task automatic release_rsp();
    @(negedge clk);
    u_if.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    u_if.rsp_ready = 1'b0;
  endtask

  // Reference: response and timing derived from the command rules
  function automatic void model(
    input  logic [1:0]  op,
    input  logic [31:0] data,
    output logic [31:0] e_data,
    output logic        e_err,
    output int          e_tries,
    output int          e_lat,
    output int          e_nstr
  );
    logic found;
    e_data = '0; e_err = 1'b0; e_tries = 0; e_lat = 0; e_nstr = 0;
    case (op)
      2'b00: begin
        e_data = vals[0]; e_tries = 1; e_nstr = 1; e_lat = RD_LAT + 2;
      end
      2'b01: begin
        e_nstr = 1; e_lat = 3;
      end
      2'b10: begin
        found = 1'b0;
        e_tries = POLL_MAX; e_err = 1'b1; e_data = vals[POLL_MAX-1];
        for (int i = 0; i < POLL_MAX; i++) begin
          if (!found && (vals[i] & data) == data) begin
            found = 1'b1; e_tries = i + 1; e_err = 1'b0; e_data = vals[i];
          end
        end
        e_nstr = e_tries;
        e_lat = 1 + (e_tries - 1) * (RD_LAT + 2) + RD_LAT + 1;
      end
      default: e_lat = int'(data[WAIT_W-1:0]) + 1;
    endcase
  endfunction

  task automatic test_reset();
    #12;
    checks++;
    if (outs_nz !== 1'b0) begin
      errors++; $display("FAIL reset_outs got %b want 0", outs_nz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (u_if.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_rdy got %b want 1", u_if.cmd_ready);
    end
    checks++;
    if (u_if.busy !== 1'b0 || u_if.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle busy %b rsp %b want 0 0",
                         u_if.busy, u_if.rsp_valid);
    end
  endtask

  task automatic test_wr();
    issue(2'b01, 32'h10, 32'hDEAD_BEEF);
    checks++;
    if (obs_lat !== 3) begin
      errors++; $display("FAIL wr_lat got %0d want 3", obs_lat);
    end
    checks++;
    if (obs_nstr !== 1 || obs_k[0] !== 1 || obs_nwr !== 1) begin
      errors++; $display("FAIL wr_strobe n %0d at %0d wr %0d want 1 1 1",
                         obs_nstr, obs_k[0], obs_nwr);
    end
    checks++;
    if (obs_addr !== 32'h10 || obs_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_bus got %h %h want 10 deadbeef",
                         obs_addr, obs_wdata);
    end
    checks++;
    if (r_data !== 32'h0 || r_tries !== 16'd0 || r_op !== 2'b01) begin
      errors++; $display("FAIL wr_rsp got %h %0d %b want 0 0 01",
                         r_data, r_tries, r_op);
    end
    checks++;
    if (obs_dirty !== 0) begin
      errors++; $display("FAIL wr_idle_bus got %0d want 0", obs_dirty);
    end
    release_rsp();
  endtask

  task automatic test_rd();
    vals[0] = 32'h1234_5678;
    issue(2'b00, 32'h20, 32'h0);
    checks++;
    if (obs_lat !== 4) begin
      errors++; $display("FAIL rd_lat got %0d want 4", obs_lat);
    end
    checks++;
    if (r_data !== 32'h1234_5678 || r_tries !== 16'd1) begin
      errors++; $display("FAIL rd_rsp got %h %0d want 12345678 1",
                         r_data, r_tries);
    end
    checks++;
    if (obs_nstr !== 1 || obs_addr !== 32'h20 || obs_nwr !== 0 ||
        obs_badrd !== 0) begin
      errors++; $display("FAIL rd_bus n %0d a %h wr %0d bad %0d",
                         obs_nstr, obs_addr, obs_nwr, obs_badrd);
    end
    release_rsp();
  endtask

  task automatic test_poll();
    for (int i = 0; i < 16; i++) vals[i] = 32'h0;
    vals[1] = 32'h2;
    vals[2] = 32'h3;
    issue(2'b10, 32'h30, 32'h1);
    checks++;
    if (obs_nstr !== 3 || obs_k[1] - obs_k[0] !== 4 ||
        obs_k[2] - obs_k[1] !== 4) begin
      errors++; $display("FAIL poll_strobes n %0d at %0d %0d %0d",
                         obs_nstr, obs_k[0], obs_k[1], obs_k[2]);
    end
    checks++;
    if (r_err !== 1'b0 || r_tries !== 16'd3 || r_data !== 32'h3) begin
      errors++; $display("FAIL poll_rsp got %b %0d %h want 0 3 3",
                         r_err, r_tries, r_data);
    end
    checks++;
    if (obs_lat !== 12 || obs_dirty !== 0) begin
      errors++; $display("FAIL poll_lat got %0d dirty %0d want 12 0",
                         obs_lat, obs_dirty);
    end
    release_rsp();
  endtask

  task automatic test_poll_timeout();
    for (int i = 0; i < 16; i++) vals[i] = 32'hFFFF_FFFE;
    vals[3] = 32'h1234_5670;
    issue(2'b10, 32'h34, 32'h1);
    checks++;
    if (obs_nstr !== 4) begin
      errors++; $display("FAIL tmo_strobes got %0d want 4", obs_nstr);
    end
    checks++;
    if (r_err !== 1'b1 || r_tries !== 16'd4 ||
        r_data !== 32'h1234_5670) begin
      errors++; $display("FAIL tmo_rsp got %b %0d %h want 1 4 12345670",
                         r_err, r_tries, r_data);
    end
    release_rsp();
    vals[0] = 32'h0;
    issue(2'b10, 32'h38, 32'h0);
    checks++;
    if (r_tries !== 16'd1 || r_err !== 1'b0 || obs_lat !== 4) begin
      errors++; $display("FAIL mask0 got %0d %b lat %0d want 1 0 4",
                         r_tries, r_err, obs_lat);
    end
    release_rsp();
  endtask

  task automatic test_wait();
    issue(2'b11, 32'h0, 32'd5);
    checks++;
    if (obs_lat !== 6 || obs_nstr !== 0 || obs_dirty !== 0) begin
      errors++; $display("FAIL wait5 lat %0d str %0d dirty %0d want 6 0 0",
                         obs_lat, obs_nstr, obs_dirty);
    end
    checks++;
    if (r_op !== 2'b11 || r_data !== 32'h0 || r_tries !== 16'd0) begin
      errors++; $display("FAIL wait_rsp got %b %h %0d want 11 0 0",
                         r_op, r_data, r_tries);
    end
    release_rsp();
    issue(2'b11, 32'h0, 32'd0);
    checks++;
    if (obs_lat !== 1) begin
      errors++; $display("FAIL wait0 lat got %0d want 1", obs_lat);
    end
    release_rsp();
    issue(2'b11, 32'h0, 32'hAB00_0002);
    checks++;
    if (obs_lat !== 3) begin
      errors++; $display("FAIL wait_trunc lat got %0d want 3", obs_lat);
    end
    release_rsp();
  endtask

  task automatic test_hold();
    int bad;
    int rdy;
    vals[0] = 32'hCAFE_F00D;
    issue(2'b00, 32'h44, 32'h0);
    bad = 0;
    rdy = 0;
    repeat (10) begin
      @(negedge clk);
      u_if.cmd_valid = 1'b1;
      u_if.cmd_op    = 2'b01;
      u_if.cmd_addr  = 32'h99;
      if ({u_if.rsp_valid, u_if.rsp_op, u_if.rsp_data, u_if.rsp_err,
           u_if.rsp_tries} !== {1'b1, r_op, r_data, r_err, r_tries})
        bad++;
      if (u_if.cmd_ready !== 1'b0) rdy++;
    end
    checks++;
    if (bad !== 0 || r_data !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL hold_stable bad %0d data %h want 0 cafef00d",
                         bad, r_data);
    end
    checks++;
    if (rdy !== 0) begin
      errors++; $display("FAIL hold_rdy got %0d want 0", rdy);
    end
    @(negedge clk);
    u_if.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    u_if.rsp_ready = 1'b0;
    u_if.cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (u_if.cmd_ready !== 1'b1 || u_if.busy !== 1'b0 ||
        u_if.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL hold_exit rdy %b busy %b rsp %b want 1 0 0",
                         u_if.cmd_ready, u_if.busy, u_if.rsp_valid);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] addr, data, mask, e_data;
    logic        e_err;
    int          e_tries, e_lat, e_nstr, t, h, bad, sp;
    for (int n = 0; n < 30; n++) begin
      op   = 2'($urandom_range(0, 3));
      addr = $urandom;
      data = $urandom;
      for (int i = 0; i < 16; i++) vals[i] = $urandom;
      if (op == 2'b10) begin
        mask = (32'h1 << $urandom_range(0, 31)) |
               (32'h1 << $urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) mask = 32'h0;
        t = $urandom_range(1, 6);
        for (int i = 0; i < 16; i++)
          vals[i] = (i < t - 1) ? ($urandom & ~mask) : ($urandom | mask);
        data = mask;
      end else if (op == 2'b11) begin
        data = {8'($urandom), 24'($urandom_range(0, 20))};
      end
      model(op, data, e_data, e_err, e_tries, e_lat, e_nstr);
      issue(op, addr, data);
      checks++;
      if (obs_rdy !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_rdy got %b want 1", n, obs_rdy);
      end
      checks++;
      if (obs_lat !== e_lat) begin
        errors++; $display("FAIL rnd%0d_lat op %b got %0d want %0d",
                           n, op, obs_lat, e_lat);
      end
      checks++;
      if (obs_nstr !== e_nstr || obs_dirty !== 0 || obs_idle !== 0) begin
        errors++; $display("FAIL rnd%0d_bus str %0d/%0d dirty %0d idle %0d",
                           n, obs_nstr, e_nstr, obs_dirty, obs_idle);
      end
      checks++;
      if (r_op !== op || r_data !== e_data || r_err !== e_err ||
          r_tries !== 16'(e_tries)) begin
        errors++; $display("FAIL rnd%0d_rsp got %b %h %b %0d want %b %h %b %0d",
                           n, r_op, r_data, r_err, r_tries,
                           op, e_data, e_err, e_tries);
      end
      sp = 0;
      for (int j = 1; j < obs_nstr && j < 16; j++)
        if (obs_k[j] - obs_k[j-1] != RD_LAT + 2) sp++;
      if (obs_nstr > 0 && obs_k[0] != 1) sp++;
      if (obs_nstr > 0 && obs_addr != addr) sp++;
      if (op == 2'b01 && obs_wdata != data) sp++;
      if (op != 2'b01 && (obs_nwr != 0 || obs_badrd != 0)) sp++;
      checks++;
      if (sp !== 0) begin
        errors++; $display("FAIL rnd%0d_strobes op %b bad %0d", n, op, sp);
      end
      h = $urandom_range(0, 3);
      bad = 0;
      repeat (h) begin
        @(negedge clk);
        if ({u_if.rsp_valid, u_if.rsp_data, u_if.rsp_err, u_if.rsp_tries,
             u_if.cmd_ready} !== {1'b1, r_data, r_err, r_tries, 1'b0})
          bad++;
      end
      checks++;
      if (bad !== 0) begin
        errors++; $display("FAIL rnd%0d_hold got %0d want 0", n, bad);
      end
      release_rsp();
    end
  endtask

  task automatic test_reset_mid_poll();
    int act;
    u_if.up_data_rd = 32'h0;
    @(negedge clk);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = 2'b10;
    u_if.cmd_addr  = 32'h30;
    u_if.cmd_data  = 32'h1;
    @(posedge clk);
    #1;
    u_if.cmd_valid = 1'b0;
    #2;
    checks++;
    if (u_if.up_cs !== 1'b1) begin
      errors++; $display("FAIL rstmid_strobe got %b want 1", u_if.up_cs);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs_nz !== 1'b0) begin
      errors++; $display("FAIL rstmid_outs got %b want 0", outs_nz);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (u_if.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_rdy got %b want 1", u_if.cmd_ready);
    end
    act = 0;
    repeat (6) begin
      @(negedge clk);
      if (u_if.rsp_valid || u_if.busy || u_if.up_cs) act++;
    end
    checks++;
    if (act !== 0) begin
      errors++; $display("FAIL rstmid_stale got %0d want 0", act);
    end
    u_if.up_data_rd = JUNK;
  endtask

  initial begin
    u_if.cmd_valid  = 1'b0;
    u_if.cmd_op     = 2'b00;
    u_if.cmd_addr   = '0;
    u_if.cmd_data   = '0;
    u_if.rsp_ready  = 1'b0;
    u_if.up_data_rd = JUNK;
    for (int i = 0; i < 16; i++) vals[i] = '0;
    test_reset();
    test_wr();
    test_rd();
    test_poll();
    test_poll_timeout();
    test_wait();
    test_hold();
    test_random();
    test_reset_mid_poll();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
